// File: rtl/fuzz_resp_checker.sv
// Response checker for fuzz runs: MISR-compresses y_dut, counts samples, records the first y_ref/y_dut mismatch.
// Optional mismatching-sample counter enabled by defining FUZZ_CHK_MISCNT_EN.
module fuzz_resp_checker #(
  parameter int          Y_W   = 376,
  parameter int          SIG_W = 32,
  parameter int          CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          BIT_W = $clog2(Y_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample,
  input  logic [Y_W-1:0]   y_ref,
  input  logic [Y_W-1:0]   y_dut,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] cnt,
  output logic             mismatch,
  output logic [CNT_W-1:0] first_idx,
  output logic [BIT_W-1:0] first_bit,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int               NSL     = (Y_W + SIG_W - 1) / SIG_W;
  localparam logic [SIG_W-1:0] POLY_S  = SIG_W'(POLY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [BIT_W-1:0] first_bit_q, first_bit_d;

  logic [Y_W-1:0]   diff_s;
  logic [SIG_W-1:0] sig_next_s;
  logic [CNT_W-1:0] cnt_next_s;

  // XOR of SIG_W-wide slices; the top slice is zero-padded
  function automatic logic [SIG_W-1:0] fold_f(input logic [Y_W-1:0] y);
    logic [NSL*SIG_W-1:0] p;
    logic [SIG_W-1:0]     f;
    p = '0;
    p[Y_W-1:0] = y;
    f = '0;
    for (int i = 0; i < NSL; i++) begin
      f = f ^ p[i*SIG_W +: SIG_W];
    end
    return f;
  endfunction

  function automatic logic [BIT_W-1:0] low_bit_f(input logic [Y_W-1:0] d);
    logic [BIT_W-1:0] b;
    b = '0;
    for (int i = Y_W - 1; i >= 0; i--) begin
      if (d[i]) b = BIT_W'(i);
    end
    return b;
  endfunction

  assign diff_s     = y_ref ^ y_dut;
  assign sig_next_s = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY_S : '0) ^ fold_f(y_dut);
  assign cnt_next_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef FUZZ_CHK_MISCNT_EN
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  assign mis_cnt = mis_cnt_q;
`else
  assign mis_cnt = '0;
`endif

  // Next-state and next-result computation for the run FSM
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    mismatch_d  = mismatch_q;
    first_idx_d = first_idx_q;
    first_bit_d = first_bit_q;
`ifdef FUZZ_CHK_MISCNT_EN
    mis_cnt_d   = mis_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          sig_d       = '0;
          cnt_d       = '0;
          mismatch_d  = 1'b0;
          first_idx_d = '0;
          first_bit_d = '0;
`ifdef FUZZ_CHK_MISCNT_EN
          mis_cnt_d   = '0;
`endif
        end else if (state_q == ST_RUN) begin
          // A sample coinciding with stop still lands before the run closes
          if (sample) begin
            sig_d = sig_next_s;
            cnt_d = cnt_next_s;
            if (diff_s != '0) begin
              if (!mismatch_q) begin
                mismatch_d  = 1'b1;
                first_idx_d = cnt_q;
                first_bit_d = low_bit_f(diff_s);
              end else begin
                mismatch_d  = 1'b1;
              end
`ifdef FUZZ_CHK_MISCNT_EN
              mis_cnt_d = (mis_cnt_q == CNT_MAX) ? mis_cnt_q : mis_cnt_q + CNT_W'(1);
`endif
            end else begin
              mismatch_d = mismatch_q;
            end
          end else begin
            sig_d = sig_q;
          end
          if (stop) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            res_valid_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (res_valid_q && res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      sig_q       <= '0;
      cnt_q       <= '0;
      mismatch_q  <= 1'b0;
      first_idx_q <= '0;
      first_bit_q <= '0;
`ifdef FUZZ_CHK_MISCNT_EN
      mis_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      mismatch_q  <= mismatch_d;
      first_idx_q <= first_idx_d;
      first_bit_q <= first_bit_d;
`ifdef FUZZ_CHK_MISCNT_EN
      mis_cnt_q   <= mis_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign sig       = sig_q;
  assign cnt       = cnt_q;
  assign mismatch  = mismatch_q;
  assign first_idx = first_idx_q;
  assign first_bit = first_bit_q;

endmodule

// File: tb/tb_fuzz_resp_checker.sv
// Directed bench for fuzz_resp_checker: a default instance and a CNT_W=4 instance share all inputs.
module tb_fuzz_resp_checker;

  logic         clk = 1'b0;
  logic         rst, start, stop, sample, res_ready;
  logic [375:0] y_ref, y_dut;

  logic         busy, res_valid, mismatch;
  logic [31:0]  sig;
  logic [15:0]  cnt, first_idx, mis_cnt;
  logic [8:0]   first_bit;

  logic         busy4, res_valid4, mismatch4;
  logic [31:0]  sig4;
  logic [3:0]   cnt4, first_idx4, mis_cnt4;
  logic [8:0]   first_bit4;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  m_sig;
  logic [15:0]  exp_mis;

  always #5 clk = ~clk;

  fuzz_resp_checker dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample(sample),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .sig(sig), .cnt(cnt), .mismatch(mismatch),
    .first_idx(first_idx), .first_bit(first_bit), .mis_cnt(mis_cnt)
  );

  fuzz_resp_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample(sample),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy4), .res_valid(res_valid4),
    .res_ready(res_ready), .sig(sig4), .cnt(cnt4), .mismatch(mismatch4),
    .first_idx(first_idx4), .first_bit(first_bit4), .mis_cnt(mis_cnt4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference MISR: bit i of y folds into signature bit i mod 32
  function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [375:0] y);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 376; i++) f[i % 32] = f[i % 32] ^ y[i];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [375:0] pattern(input int i);
    logic [383:0] w;
    w = {12{32'h9E3779B9 + 32'(i)}};
    return w[375:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    m_sig = 32'h0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic do_sample(input logic [375:0] r, input logic [375:0] d);
    y_ref = r; y_dut = d; sample = 1'b1;
    tick();
    sample = 1'b0;
    m_sig = misr_model(m_sig, d);
  endtask

  task automatic accept();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  initial begin
    logic [375:0] r, d, flip;
    logic [31:0]  held_sig;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample = 1'b0; res_ready = 1'b0;
    y_ref = '0; y_dut = '0; m_sig = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(res_valid), 64'd0);
    check_eq("rst_sig", 64'(sig), 64'd0);
    check_eq("rst_cnt", 64'(cnt), 64'd0);
    check_eq("rst_mis", 64'(mismatch), 64'd0);
    check_eq("rst_fidx", 64'(first_idx), 64'd0);
    check_eq("rst_fbit", 64'(first_bit), 64'd0);
    check_eq("rst_miscnt", 64'(mis_cnt), 64'd0);

    // 1: two matching samples 1 then 0
    pulse_start();
    check_eq("t1_busy", 64'(busy), 64'd1);
    do_sample(376'd1, 376'd1);
    do_sample(376'd0, 376'd0);
    pulse_stop();
    check_eq("t1_sig", 64'(sig), 64'h2);
    check_eq("t1_cnt", 64'(cnt), 64'd2);
    check_eq("t1_mis", 64'(mismatch), 64'd0);
    check_eq("t1_valid", 64'(res_valid), 64'd1);
    check_eq("t1_busy_done", 64'(busy), 64'd0);
    accept();
    check_eq("t1_valid_drop", 64'(res_valid), 64'd0);
    check_eq("t1_cnt_held", 64'(cnt), 64'd2);

    // 2: mismatch at bits 7 and 200 on sample 3
    flip = '0; flip[7] = 1'b1; flip[200] = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      r = pattern(i);
      d = (i == 3) ? (r ^ flip) : r;
      do_sample(r, d);
    end
    pulse_stop();
`ifdef FUZZ_CHK_MISCNT_EN
    exp_mis = 16'd1;
`else
    exp_mis = 16'd0;
`endif
    check_eq("t2_mis", 64'(mismatch), 64'd1);
    check_eq("t2_fidx", 64'(first_idx), 64'd3);
    check_eq("t2_fbit", 64'(first_bit), 64'd7);
    check_eq("t2_miscnt", 64'(mis_cnt), 64'(exp_mis));
    check_eq("t2_cnt", 64'(cnt), 64'd5);
    check_eq("t2_sig", 64'(sig), 64'(m_sig));

    // 3: DONE holds while consumer stalls
    for (int i = 0; i < 4; i++) begin
      sample = i[0]; start = ~i[0]; stop = i[0];
      y_ref = pattern(7); y_dut = ~pattern(7);
      tick();
      check_eq("t3_valid", 64'(res_valid), 64'd1);
      check_eq("t3_cnt", 64'(cnt), 64'd5);
      check_eq("t3_sig", 64'(sig), 64'(m_sig));
      check_eq("t3_busy", 64'(busy), 64'd0);
    end
    sample = 1'b0; start = 1'b0; stop = 1'b0;
    accept();
    check_eq("t3_valid_drop", 64'(res_valid), 64'd0);
    check_eq("t3_fidx_held", 64'(first_idx), 64'd3);
    check_eq("t3_sig_held", 64'(sig), 64'(m_sig));
    tick();
    check_eq("t3_idle_busy", 64'(busy), 64'd0);

    // 4: sample with stop, then restart mid-run
    pulse_start();
    do_sample(pattern(1), pattern(1));
    y_ref = pattern(2); y_dut = pattern(2); sample = 1'b1; stop = 1'b1;
    tick();
    sample = 1'b0; stop = 1'b0;
    m_sig = misr_model(m_sig, pattern(2));
    check_eq("t4_cnt", 64'(cnt), 64'd2);
    check_eq("t4_valid", 64'(res_valid), 64'd1);
    check_eq("t4_sig", 64'(sig), 64'(m_sig));
    accept();
    pulse_start();
    do_sample(pattern(3), pattern(3));
    do_sample(pattern(4), pattern(4) ^ flip);
    check_eq("t4_pre_sig", 64'(sig), 64'(m_sig));
    start = 1'b1; sample = 1'b1;
    tick();
    start = 1'b0; sample = 1'b0; m_sig = 32'h0;
    check_eq("t4_rs_cnt", 64'(cnt), 64'd0);
    check_eq("t4_rs_sig", 64'(sig), 64'd0);
    check_eq("t4_rs_mis", 64'(mismatch), 64'd0);
    check_eq("t4_rs_busy", 64'(busy), 64'd1);

    // 5: reset during RUN and during DONE
    for (int i = 0; i < 3; i++) do_sample(pattern(i), pattern(i) ^ flip);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_run_busy", 64'(busy), 64'd0);
    check_eq("t5_run_valid", 64'(res_valid), 64'd0);
    check_eq("t5_run_sig", 64'(sig), 64'd0);
    check_eq("t5_run_cnt", 64'(cnt), 64'd0);
    check_eq("t5_run_mis", 64'(mismatch), 64'd0);
    check_eq("t5_run_fbit", 64'(first_bit), 64'd0);
    pulse_start();
    do_sample(pattern(5), pattern(5) ^ flip);
    pulse_stop();
    check_eq("t5_done_valid", 64'(res_valid), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_done_valid0", 64'(res_valid), 64'd0);
    check_eq("t5_done_sig", 64'(sig), 64'd0);
    check_eq("t5_done_cnt", 64'(cnt), 64'd0);
    check_eq("t5_done_mis", 64'(mismatch), 64'd0);
    check_eq("t5_done_miscnt", 64'(mis_cnt), 64'd0);

    // 6: counter saturation on the CNT_W=4 instance
    flip = '0; flip[100] = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      r = pattern(i + 10);
      d = (i == 18) ? (r ^ flip) : r;
      do_sample(r, d);
      if (i >= 16) check_eq("t6_sig4", 64'(sig4), 64'(m_sig));
    end
    pulse_stop();
    check_eq("t6_cnt4", 64'(cnt4), 64'd15);
    check_eq("t6_fidx4", 64'(first_idx4), 64'd15);
    check_eq("t6_fbit4", 64'(first_bit4), 64'd100);
    check_eq("t6_mis4", 64'(mismatch4), 64'd1);
    check_eq("t6_cnt", 64'(cnt), 64'd20);
    check_eq("t6_fidx", 64'(first_idx), 64'd18);
    check_eq("t6_sig", 64'(sig), 64'(m_sig));
    held_sig = sig4;
    accept();
    check_eq("t6_sig4_held", 64'(sig4), 64'(held_sig));
    check_eq("t6_valid4_drop", 64'(res_valid4), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
